memory_cycle: RTL and testbench
===============================

Name: memory_cycle

Overview:
- Memory stage of the 5-stage RISC-V pipeline; the receiving end of the execute-to-memory interface driven by execute_cycle.
- Consumes the M-stage control and data bundle and performs the data-memory access against an internal word-addressed data memory.
- Registers the results into the M/W pipeline register, which feeds writeback and the W-stage forwarding path.

Parameters:
- DMEM_WORDS, 1024, number of 32-bit words in the internal data memory; must be a power of two.
- ADDR_BITS, 10, word-index width; must equal log2(DMEM_WORDS).

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- RegWriteM  input  1  register-file write enable from the E/M register.
- MemWriteM  input  1  data-memory store enable.
- ResultSrcM  input  1  writeback select: 0 = ALU result, 1 = load data.
- RD_M  input  5  destination register index.
- PCPlus4M  input  32  PC+4 of the instruction in the M stage.
- WriteDataM  input  32  store data.
- ALU_ResultM  input  32  effective byte address, or the ALU result.
- RegWriteW  output  1  registered RegWriteM, gated by fault (see Behaviour).
- ResultSrcW  output  1  registered ResultSrcM.
- RD_W  output  5  registered RD_M.
- PCPlus4W  output  32  registered PCPlus4M.
- ALU_ResultW  output  32  registered ALU_ResultM.
- ReadDataW  output  32  registered load data.
- AccessFaultW  output  1  registered fault flag for the M-stage access.

Behaviour:
- Reset (rst = 0, asynchronous): all W outputs go to 0 immediately, including AccessFaultW.
- The memory array is not reset; its contents are retained across reset and are undefined at power-up.
- Latency: exactly one cycle. Values on the M inputs before edge N appear on the W outputs after edge N. There is no stall and no bubble insertion inside the block.
- Address decode:
  - word index = ALU_ResultM[ADDR_BITS+1:2].
  - misaligned = ALU_ResultM[1:0] != 0.
  - out-of-range = ALU_ResultM[31:ADDR_BITS+2] != 0.
  - fault = (misaligned or out-of-range) and (MemWriteM or (ResultSrcM and RegWriteM)).
- Store: on the rising edge with rst = 1, MemWriteM = 1 and no fault, mem[index] <= WriteDataM. A faulting store is dropped and memory is unchanged.
- Load read:
  - Combinational read of mem[index], captured into ReadDataW on the same edge.
  - A faulting access captures 0 instead.
  - When ResultSrcM = 0, ReadDataW still captures the array value (don't-care downstream), or 0 if out-of-range.
- Read-during-write to the same index in the same cycle: ReadDataW captures the OLD contents (read-before-write). The new data is visible from the next cycle.
- Fault handling:
  - AccessFaultW <= fault.
  - RegWriteW <= RegWriteM and not fault, so a faulting load never writes the register file.
- Pass-through: ResultSrcW, RD_W, PCPlus4W and ALU_ResultW register their M inputs unmodified, even on fault.
- A store with RegWriteM = 1 is legal; RegWriteW follows the rule above.
- Reset asserted mid-store: an edge coinciding with rst = 0 performs no write.
- Reset released between edges: the first edge after release samples normally.

Test Plan:
- Reset: hold rst = 0 for 2 cycles with random M inputs -> all W outputs 0; deassert -> the first edge registers the inputs.
- Store/load: store WriteDataM = 32'hDEADBEEF at ALU_ResultM = 32'h0000_0010, then load the same address with ResultSrcM = 1, RegWriteM = 1, RD_M = 5 -> one cycle later ReadDataW = 32'hDEADBEEF, RD_W = 5, RegWriteW = 1, AccessFaultW = 0.
- Read-before-write: mem[4] = 32'h1111_1111; in one cycle set MemWriteM = 1, WriteDataM = 32'h2222_2222, address 32'h10 -> ReadDataW = 32'h1111_1111; a load on the next cycle returns 32'h2222_2222.
- Misaligned store at 32'h0000_0012 -> memory unchanged (a later load of 32'h10 returns the old value), AccessFaultW = 1.
- Misaligned load at 32'h0000_0012 with RegWriteM = 1 -> RegWriteW = 0, ReadDataW = 0, AccessFaultW = 1.
- Out-of-range load at 32'h0000_1000 (DMEM_WORDS = 1024) -> AccessFaultW = 1, ReadDataW = 0.
- Last word 32'h0000_0FFC stores and loads correctly with no fault.
- ALU op, no memory access: RegWriteM = 1, ResultSrcM = 0, ALU_ResultM = 32'h0000_0013 (misaligned value), PCPlus4M = 32'h8 -> AccessFaultW = 0, RegWriteW = 1, ALU_ResultW = 32'h13, PCPlus4W = 32'h8.

Source files
------------

// File: rtl/memory_cycle.sv
// rtl/memory_cycle.sv - M stage: data-memory access and the M/W pipeline register
module memory_cycle #(
   parameter int DMEM_WORDS = 1024,
   parameter int ADDR_BITS  = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        RegWriteM,
   input  logic        MemWriteM,
   input  logic        ResultSrcM,
   input  logic [4:0]  RD_M,
   input  logic [31:0] PCPlus4M,
   input  logic [31:0] WriteDataM,
   input  logic [31:0] ALU_ResultM,
   output logic        RegWriteW,
   output logic        ResultSrcW,
   output logic [4:0]  RD_W,
   output logic [31:0] PCPlus4W,
   output logic [31:0] ALU_ResultW,
   output logic [31:0] ReadDataW,
   output logic        AccessFaultW
);

   logic [31:0]          mem [DMEM_WORDS];
   logic [ADDR_BITS-1:0] index;
   logic                 misaligned;
   logic                 out_of_range;
   logic                 mem_access;
   logic                 fault;
   logic [31:0]          read_data;

   assign index        = ALU_ResultM[ADDR_BITS+1:2];
   assign misaligned   = |ALU_ResultM[1:0];
   assign out_of_range = |ALU_ResultM[31:ADDR_BITS+2];
   // Only real loads and stores can fault; plain ALU results may carry any value.
   assign mem_access   = MemWriteM | (ResultSrcM & RegWriteM);
   assign fault        = (misaligned | out_of_range) & mem_access;
   assign read_data    = (fault | out_of_range) ? 32'h0 : mem[index];

   // Array has no reset; the reset term only blocks a store on an edge taken while in reset.
   always_ff @(posedge clk or negedge rst) begin
      if (rst) begin
         if (MemWriteM && !fault) begin
            mem[index] <= WriteDataM;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         RegWriteW    <= 1'b0;
         ResultSrcW   <= 1'b0;
         RD_W         <= 5'd0;
         PCPlus4W     <= 32'h0;
         ALU_ResultW  <= 32'h0;
         ReadDataW    <= 32'h0;
         AccessFaultW <= 1'b0;
      end else begin
         RegWriteW    <= RegWriteM & ~fault;
         ResultSrcW   <= ResultSrcM;
         RD_W         <= RD_M;
         PCPlus4W     <= PCPlus4M;
         ALU_ResultW  <= ALU_ResultM;
         ReadDataW    <= read_data;
         AccessFaultW <= fault;
      end
   end

endmodule

// File: tb/tb_memory_cycle.sv
// tb/tb_memory_cycle.sv - scoreboard bench for memory_cycle
module tb_memory_cycle;

   typedef struct packed {
      logic        rw;
      logic        mw;
      logic        rs;
      logic [4:0]  rd;
      logic [31:0] pc;
      logic [31:0] wd;
      logic [31:0] alu;
   } min_t;

   typedef struct packed {
      logic        rw;
      logic        rs;
      logic [4:0]  rd;
      logic [31:0] pc;
      logic [31:0] alu;
      logic [31:0] rdata;
      logic        fault;
   } wout_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        RegWriteM = 1'b0, MemWriteM = 1'b0, ResultSrcM = 1'b0;
   logic [4:0]  RD_M = 5'd0;
   logic [31:0] PCPlus4M = 32'h0, WriteDataM = 32'h0, ALU_ResultM = 32'h0;
   logic        RegWriteW, ResultSrcW, AccessFaultW;
   logic [4:0]  RD_W;
   logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;

   int    n_checks = 0;
   int    n_fail   = 0;
   wout_t exp_q[$];
   logic [31:0] mem_m [1024];
   wout_t exp, obs;

   memory_cycle #(.DMEM_WORDS(1024), .ADDR_BITS(10)) dut (
      .clk(clk), .rst(rst),
      .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
      .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM),
      .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W), .PCPlus4W(PCPlus4W),
      .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW), .AccessFaultW(AccessFaultW)
   );

   always #5 clk = ~clk;

   function automatic wout_t sample();
      wout_t s;
      s.rw = RegWriteW; s.rs = ResultSrcW; s.rd = RD_W; s.pc = PCPlus4W;
      s.alu = ALU_ResultW; s.rdata = ReadDataW; s.fault = AccessFaultW;
      return s;
   endfunction

   function automatic string fmt(input wout_t s);
      return $sformatf("rw=%b rs=%b rd=%0d pc=%h alu=%h rdata=%h fault=%b",
                       s.rw, s.rs, s.rd, s.pc, s.alu, s.rdata, s.fault);
   endfunction

   function automatic min_t mk(input logic rw, input logic mw, input logic rs, input logic [4:0] rd,
                               input logic [31:0] pc, input logic [31:0] wd, input logic [31:0] alu);
      min_t i;
      i.rw = rw; i.mw = mw; i.rs = rs; i.rd = rd; i.pc = pc; i.wd = wd; i.alu = alu;
      return i;
   endfunction

   // Drive one M-stage bundle, push the reference result, advance one edge.
   task automatic step(input min_t i);
      wout_t e;
      logic  mis, oor, f;
      RegWriteM = i.rw; MemWriteM = i.mw; ResultSrcM = i.rs; RD_M = i.rd;
      PCPlus4M = i.pc; WriteDataM = i.wd; ALU_ResultM = i.alu;
      mis = (i.alu[1:0] != 2'b00);
      oor = (i.alu[31:12] != 20'h0);
      f   = (mis | oor) & (i.mw | (i.rs & i.rw));
      e.rw = i.rw & ~f; e.rs = i.rs; e.rd = i.rd; e.pc = i.pc; e.alu = i.alu; e.fault = f;
      e.rdata = (f | oor) ? 32'h0 : mem_m[i.alu[11:2]];
      if (i.mw && !f) mem_m[i.alu[11:2]] = i.wd;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      min_t i;
      i = mk(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), $urandom, $urandom,
             $urandom | 32'h8000_0000);
      RegWriteM = i.rw; MemWriteM = i.mw; ResultSrcM = i.rs; RD_M = i.rd;
      PCPlus4M = i.pc; WriteDataM = i.wd; ALU_ResultM = i.alu;
      for (int c = 0; c < 2; c++) begin
         @(posedge clk);
         #1;
         obs = sample();
         n_checks++;
         if (obs !== '0) begin
            n_fail++;
            $display("FAIL reset_hold%0d: got %s, want all zero", c, fmt(obs));
         end
      end
      rst = 1'b1;
      step(i);
      exp = exp_q.pop_front();
      obs = sample();
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL reset_release: got %s, want %s", fmt(obs), fmt(exp));
      end
   endtask

   // Fill every word later read so no check depends on power-up contents.
   task automatic preload();
      logic [31:0] addrs [4];
      addrs[0] = 32'h0; addrs[1] = 32'h10; addrs[2] = 32'h20; addrs[3] = 32'hFFC;
      for (int k = 0; k < 4; k++) begin
         step(mk(1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 32'hA5A5_0000 + k, addrs[k]));
         exp = exp_q.pop_front();
      end
   endtask

   task automatic test_store_load();
      step(mk(1'b0, 1'b1, 1'b0, 5'd0, 32'h100, 32'hDEAD_BEEF, 32'h10));
      exp = exp_q.pop_front();
      step(mk(1'b1, 1'b0, 1'b1, 5'd5, 32'h104, 32'h0, 32'h10));
      exp = exp_q.pop_front();
      obs = sample();
      n_checks++;
      if (obs !== exp || obs.rdata !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL store_load: got %s, want %s", fmt(obs), fmt(exp));
      end
   endtask

   task automatic test_read_before_write();
      step(mk(1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 32'h1111_1111, 32'h10));
      exp = exp_q.pop_front();
      step(mk(1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 32'h2222_2222, 32'h10));
      exp = exp_q.pop_front();
      obs = sample();
      n_checks++;
      if (obs !== exp || obs.rdata !== 32'h1111_1111) begin
         n_fail++;
         $display("FAIL rbw_old: got %s, want %s", fmt(obs), fmt(exp));
      end
      step(mk(1'b1, 1'b0, 1'b1, 5'd7, 32'h0, 32'h0, 32'h10));
      exp = exp_q.pop_front();
      obs = sample();
      n_checks++;
      if (obs !== exp || obs.rdata !== 32'h2222_2222) begin
         n_fail++;
         $display("FAIL rbw_new: got %s, want %s", fmt(obs), fmt(exp));
      end
   endtask

   task automatic test_misaligned();
      step(mk(1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 32'h3333_3333, 32'h12));
      exp = exp_q.pop_front();
      obs = sample();
      n_checks++;
      if (obs !== exp || obs.fault !== 1'b1) begin
         n_fail++;
         $display("FAIL misaligned_store: got %s, want %s", fmt(obs), fmt(exp));
      end
      step(mk(1'b1, 1'b0, 1'b1, 5'd9, 32'h0, 32'h0, 32'h10));
      exp = exp_q.pop_front();
      obs = sample();
      n_checks++;
      if (obs !== exp || obs.rdata !== 32'h2222_2222) begin
         n_fail++;
         $display("FAIL misaligned_store_dropped: got %s, want %s", fmt(obs), fmt(exp));
      end
      step(mk(1'b1, 1'b0, 1'b1, 5'd9, 32'h0, 32'h0, 32'h12));
      exp = exp_q.pop_front();
      obs = sample();
      n_checks++;
      if (obs !== exp || obs.rw !== 1'b0 || obs.rdata !== 32'h0 || obs.fault !== 1'b1) begin
         n_fail++;
         $display("FAIL misaligned_load: got %s, want %s", fmt(obs), fmt(exp));
      end
   endtask

   task automatic test_out_of_range();
      step(mk(1'b1, 1'b0, 1'b1, 5'd3, 32'h0, 32'h0, 32'h1000));
      exp = exp_q.pop_front();
      obs = sample();
      n_checks++;
      if (obs !== exp || obs.fault !== 1'b1 || obs.rdata !== 32'h0) begin
         n_fail++;
         $display("FAIL out_of_range_load: got %s, want %s", fmt(obs), fmt(exp));
      end
   endtask

   task automatic test_last_word();
      step(mk(1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 32'hCAFE_F00D, 32'hFFC));
      exp = exp_q.pop_front();
      obs = sample();
      n_checks++;
      if (obs !== exp || obs.fault !== 1'b0) begin
         n_fail++;
         $display("FAIL last_word_store: got %s, want %s", fmt(obs), fmt(exp));
      end
      step(mk(1'b1, 1'b0, 1'b1, 5'd31, 32'h0, 32'h0, 32'hFFC));
      exp = exp_q.pop_front();
      obs = sample();
      n_checks++;
      if (obs !== exp || obs.rdata !== 32'hCAFE_F00D) begin
         n_fail++;
         $display("FAIL last_word_load: got %s, want %s", fmt(obs), fmt(exp));
      end
   endtask

   task automatic test_alu_op();
      step(mk(1'b1, 1'b0, 1'b0, 5'd12, 32'h8, 32'h0, 32'h13));
      exp = exp_q.pop_front();
      obs = sample();
      n_checks++;
      if (obs !== exp || obs.fault !== 1'b0 || obs.rw !== 1'b1 || obs.alu !== 32'h13 ||
          obs.pc !== 32'h8) begin
         n_fail++;
         $display("FAIL alu_op: got %s, want %s", fmt(obs), fmt(exp));
      end
   endtask

   task automatic test_reset_mid_store();
      step(mk(1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 32'h4444_4444, 32'h20));
      exp = exp_q.pop_front();
      step(mk(1'b1, 1'b0, 1'b1, 5'd1, 32'h55, 32'h0, 32'h20));
      exp = exp_q.pop_front();
      RegWriteM = 1'b0; MemWriteM = 1'b1; ResultSrcM = 1'b0;
      WriteDataM = 32'h5555_5555; ALU_ResultM = 32'h20;
      #2;
      rst = 1'b0;
      #1;
      obs = sample();
      n_checks++;
      if (obs !== '0) begin
         n_fail++;
         $display("FAIL async_reset: got %s, want all zero", fmt(obs));
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      step(mk(1'b1, 1'b0, 1'b1, 5'd2, 32'h0, 32'h0, 32'h20));
      exp = exp_q.pop_front();
      obs = sample();
      n_checks++;
      if (obs !== exp || obs.rdata !== 32'h4444_4444) begin
         n_fail++;
         $display("FAIL reset_blocks_store: got %s, want %s", fmt(obs), fmt(exp));
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] base [4];
      logic [31:0] a;
      base[0] = 32'h0; base[1] = 32'h10; base[2] = 32'h20; base[3] = 32'hFFC;
      for (int n = 0; n < 60; n++) begin
         a = base[$urandom_range(0, 3)];
         if ($urandom_range(0, 3) == 0) a = a | 32'($urandom_range(1, 3));
         if ($urandom_range(0, 7) == 0) a = a | 32'h0001_0000;
         step(mk(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), $urandom, $urandom, a));
         exp = exp_q.pop_front();
         obs = sample();
         n_checks++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL back_to_back[%0d]: got %s, want %s", n, fmt(obs), fmt(exp));
         end
      end
   endtask

   initial begin
      test_reset();
      preload();
      test_store_load();
      test_read_before_write();
      test_misaligned();
      test_out_of_range();
      test_last_word();
      test_alu_op();
      test_reset_mid_store();
      test_back_to_back();
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d entries left, want 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
